// File: rtl/encoder_param_select.sv
// Two-mode rotary UI: NAVIGATE selects a parameter, EDIT adjusts a saturating shadow copy.
// Optional detent acceleration is enabled by defining ENC_ACCEL_EN.
module encoder_param_select #(
  parameter int NUM_PARAMS     = 4,
  parameter int VAL_W          = 8,
  parameter int VAL_MIN        = 0,
  parameter int VAL_MAX        = 255,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int ACCEL_WINDOW   = 2500000,
  parameter int ACCEL_GAIN     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   position,
  input  logic                          btn_pulse,
  output logic [$clog2(NUM_PARAMS)-1:0] sel_idx,
  output logic                          editing,
  output logic [VAL_W-1:0]              edit_value,
  output logic [NUM_PARAMS*VAL_W-1:0]   param_flat,
  output logic                          commit_pulse,
  output logic                          abort_pulse
);

  localparam int IW = $clog2(NUM_PARAMS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = VAL_W + 20;
  localparam logic signed [SW-1:0] MIN_S = SW'(VAL_MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(VAL_MAX);

  typedef enum logic {NAVIGATE, EDIT} state_t;

  state_t                 state, state_nxt;
  logic [15:0]            pos_prev, delta;
  logic [VAL_W-1:0]       params [NUM_PARAMS];
  logic [VAL_W-1:0]       shadow, shadow_nxt, sat_val;
  logic [TW-1:0]          tcnt, tcnt_nxt;
  logic [IW-1:0]          sel_nxt;
  logic                   commit_nxt, abort_nxt, wr_en;
  logic signed [SW-1:0]   step, sum;

`ifdef ENC_ACCEL_EN
  localparam int WW = $clog2(ACCEL_WINDOW + 1);
  localparam logic signed [SW-1:0] GAIN_S = SW'(ACCEL_GAIN);
  logic [WW-1:0] wcnt, wcnt_nxt;
`endif

  // Wrapping difference makes a 32767 -> -32768 rollover read as +1.
  assign delta = position - pos_prev;

  always_comb begin
    step = {{(SW-16){delta[15]}}, delta};
`ifdef ENC_ACCEL_EN
    if (wcnt < WW'(ACCEL_WINDOW)) step = step * GAIN_S;
`endif
    sum = $signed({{(SW-VAL_W){1'b0}}, shadow}) + step;
    if (sum < MIN_S)      sat_val = VAL_W'(VAL_MIN);
    else if (sum > MAX_S) sat_val = VAL_W'(VAL_MAX);
    else                  sat_val = sum[VAL_W-1:0];
  end

  // Button outranks timeout, which outranks rotation.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_idx;
    shadow_nxt = shadow;
    tcnt_nxt   = tcnt;
    commit_nxt = 1'b0;
    abort_nxt  = 1'b0;
    wr_en      = 1'b0;
`ifdef ENC_ACCEL_EN
    wcnt_nxt   = (wcnt == WW'(ACCEL_WINDOW)) ? wcnt : wcnt + WW'(1);
`endif
    case (state)
      NAVIGATE: begin
        if (btn_pulse) begin
          state_nxt  = EDIT;
          shadow_nxt = params[sel_idx];
          tcnt_nxt   = '0;
`ifdef ENC_ACCEL_EN
          wcnt_nxt   = WW'(ACCEL_WINDOW);
`endif
        end else if (delta != 16'd0) begin
          sel_nxt = delta[15] ? sel_idx - IW'(1) : sel_idx + IW'(1);
        end
      end
      EDIT: begin
        if (btn_pulse) begin
          state_nxt  = NAVIGATE;
          wr_en      = 1'b1;
          commit_nxt = 1'b1;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = NAVIGATE;
          abort_nxt = 1'b1;
        end else if (delta != 16'd0) begin
          shadow_nxt = sat_val;
          tcnt_nxt   = '0;
`ifdef ENC_ACCEL_EN
          wcnt_nxt   = '0;
`endif
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      default: state_nxt = NAVIGATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NAVIGATE;
      pos_prev     <= '0;
      sel_idx      <= '0;
      shadow       <= VAL_W'(VAL_MIN);
      tcnt         <= '0;
      commit_pulse <= 1'b0;
      abort_pulse  <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) params[i] <= VAL_W'(VAL_MIN);
`ifdef ENC_ACCEL_EN
      wcnt         <= WW'(ACCEL_WINDOW);
`endif
    end else begin
      state        <= state_nxt;
      pos_prev     <= position;
      sel_idx      <= sel_nxt;
      shadow       <= shadow_nxt;
      tcnt         <= tcnt_nxt;
      commit_pulse <= commit_nxt;
      abort_pulse  <= abort_nxt;
      if (wr_en) params[sel_idx] <= shadow;
`ifdef ENC_ACCEL_EN
      wcnt         <= wcnt_nxt;
`endif
    end
  end

  assign editing    = (state == EDIT);
  assign edit_value = editing ? shadow : params[sel_idx];

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
    assign param_flat[g*VAL_W +: VAL_W] = params[g];
  end

endmodule

// File: tb/tb_encoder_param_select.sv
// Self-checking bench for encoder_param_select: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the UI rules.
module tb_encoder_param_select;

  localparam int N  = 4;
  localparam int T  = 100;
  localparam int W  = 10;
  localparam int G  = 4;
`ifdef ENC_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] position;
  logic        btn_pulse;
  logic [1:0]  sel_idx;
  logic        editing;
  logic [7:0]  edit_value;
  logic [31:0] param_flat;
  logic        commit_pulse, abort_pulse;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_prev;
  bit          m_edit, m_commit, m_abort;
  int          m_sel, m_shadow, m_idle, m_win;
  int          m_params [N];
  logic [15:0] cur_pos;

  encoder_param_select #(
    .NUM_PARAMS(N), .VAL_W(8), .VAL_MIN(0), .VAL_MAX(255),
    .TIMEOUT_CYCLES(T), .ACCEL_WINDOW(W), .ACCEL_GAIN(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .position(position), .btn_pulse(btn_pulse),
    .sel_idx(sel_idx), .editing(editing), .edit_value(edit_value),
    .param_flat(param_flat), .commit_pulse(commit_pulse), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_prev = 16'd0; m_edit = 0; m_commit = 0; m_abort = 0;
    m_sel = 0; m_shadow = 0; m_idle = 0; m_win = W;
    for (int i = 0; i < N; i++) m_params[i] = 0;
  endtask

  // One clock of the UI rules, evaluated with plain integer arithmetic.
  task automatic m_step(input logic [15:0] p, input bit b);
    logic signed [15:0] d;
    int di, stp;
    bit took;
    d = $signed(p - m_prev);
    di = int'(d);
    m_prev = p;
    m_commit = 0; m_abort = 0; took = 0;
    if (!m_edit) begin
      if (b) begin
        m_edit = 1; m_shadow = m_params[m_sel]; m_idle = 0; m_win = W; took = 1;
      end else if (di != 0) begin
        m_sel = (m_sel + ((di > 0) ? 1 : N - 1)) % N;
      end
    end else begin
      if (b) begin
        m_params[m_sel] = m_shadow; m_commit = 1; m_edit = 0;
      end else if (m_idle == T - 1) begin
        m_abort = 1; m_edit = 0;
      end else if (di != 0) begin
        stp = (ACC && m_win < W) ? di * G : di;
        m_shadow = m_shadow + stp;
        if (m_shadow < 0) m_shadow = 0;
        if (m_shadow > 255) m_shadow = 255;
        m_idle = 0; m_win = 0; took = 1;
      end else begin
        m_idle++;
      end
    end
    if (!took && m_win < W) m_win++;
  endtask

  function automatic logic [44:0] m_outputs();
    logic [31:0] pf;
    for (int i = 0; i < N; i++) pf[i*8 +: 8] = m_params[i][7:0];
    return {m_sel[1:0], m_edit, (m_edit ? m_shadow[7:0] : m_params[m_sel][7:0]),
            pf, m_commit, m_abort};
  endfunction

  task automatic drive(input logic [15:0] p, input bit b);
    position = p; btn_pulse = b; cur_pos = p;
    @(posedge clk);
    m_step(p, b);
    #1;
    btn_pulse = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({sel_idx, editing, edit_value, param_flat, commit_pulse, abort_pulse} !== 45'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got sel=%0d edit=%0b val=%0d flat=%h, required all zero",
               sel_idx, editing, edit_value, param_flat);
    end
  endtask

  task automatic test_nav_wrap();
    drive(16'hFFFF, 0);
    checks++;
    if (sel_idx !== 2'd3) begin failures++; $display("[TB] FAIL nav_wrap_down: got %0d required 3", sel_idx); end
    drive(16'd3, 0);
    checks++;
    if (sel_idx !== 2'd0) begin failures++; $display("[TB] FAIL nav_big_jump: got %0d required 0", sel_idx); end
  endtask

  task automatic test_commit();
    logic [7:0] exp_v;
    exp_v = ACC ? 8'd17 : 8'd5;
    drive(cur_pos, 1);
    checks++;
    if (editing !== 1'b1) begin failures++; $display("[TB] FAIL commit_enter: editing=%0b required 1", editing); end
    for (int i = 0; i < 5; i++) drive(cur_pos + 16'd1, 0);
    checks++;
    if (edit_value !== exp_v) begin failures++; $display("[TB] FAIL commit_shadow: got %0d required %0d", edit_value, exp_v); end
    drive(cur_pos, 1);
    checks++;
    if ({commit_pulse, editing, param_flat[7:0]} !== {1'b1, 1'b0, exp_v}) begin
      failures++;
      $display("[TB] FAIL commit_apply: pulse=%0b edit=%0b p0=%0d required 1,0,%0d",
               commit_pulse, editing, param_flat[7:0], exp_v);
    end
    drive(cur_pos, 0);
    checks++;
    if (commit_pulse !== 1'b0) begin failures++; $display("[TB] FAIL commit_one_cycle: got %0b required 0", commit_pulse); end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_w;
    exp_w = ACC ? 8'd4 : 8'd1;
    drive(cur_pos + 16'd1, 0);
    drive(cur_pos, 1);
    checks++;
    if ({sel_idx, editing} !== {2'd1, 1'b1}) begin failures++; $display("[TB] FAIL sat_enter: sel=%0d edit=%0b required 1,1", sel_idx, editing); end
    drive(cur_pos + 16'd300, 0);
    checks++;
    if (edit_value !== 8'd255) begin failures++; $display("[TB] FAIL sat_high: got %0d required 255", edit_value); end
    drive(cur_pos - 16'd1000, 0);
    checks++;
    if (edit_value !== 8'd0) begin failures++; $display("[TB] FAIL sat_low: got %0d required 0", edit_value); end
    drive(16'h7FFF, 0);
    drive(16'h8000, 0);
    checks++;
    if (edit_value !== exp_w) begin failures++; $display("[TB] FAIL sat_pos_wrap: got %0d required %0d", edit_value, exp_w); end
    drive(cur_pos, 1);
    checks++;
    if (param_flat[15:8] !== exp_w) begin failures++; $display("[TB] FAIL sat_commit: got %0d required %0d", param_flat[15:8], exp_w); end
  endtask

  task automatic test_timeout();
    int aborts;
    aborts = 0;
    drive(cur_pos + 16'd1, 0);
    drive(cur_pos, 1);
    drive(cur_pos + 16'd1, 0);
    checks++;
    if ({sel_idx, editing, edit_value} !== {2'd2, 1'b1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL timeout_setup: sel=%0d edit=%0b val=%0d required 2,1,1", sel_idx, editing, edit_value);
    end
    for (int i = 1; i <= T; i++) begin
      drive(cur_pos, 0);
      if (abort_pulse === 1'b1) aborts++;
      if (i == T - 1) begin
        checks++;
        if ({editing, abort_pulse} !== 2'b10) begin failures++; $display("[TB] FAIL timeout_early: edit=%0b abort=%0b required 1,0", editing, abort_pulse); end
      end
    end
    checks++;
    if ({abort_pulse, editing, edit_value, param_flat[23:16]} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("[TB] FAIL timeout_abort: abort=%0b edit=%0b val=%0d p2=%0d required 1,0,0,0",
               abort_pulse, editing, edit_value, param_flat[23:16]);
    end
    drive(cur_pos, 0);
    if (abort_pulse === 1'b1) aborts++;
    checks++;
    if (aborts != 1) begin failures++; $display("[TB] FAIL timeout_once: abort count %0d required 1", aborts); end
  endtask

  task automatic test_priority();
    drive(cur_pos + 16'd1, 1);
    checks++;
    if ({editing, sel_idx} !== {1'b1, 2'd2}) begin failures++; $display("[TB] FAIL prio_btn_delta: edit=%0b sel=%0d required 1,2", editing, sel_idx); end
  endtask

  task automatic test_async_reset();
    drive(cur_pos + 16'd2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_idx, editing, edit_value, param_flat, commit_pulse, abort_pulse} !== 45'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: sel=%0d edit=%0b val=%0d flat=%h required all zero",
               sel_idx, editing, edit_value, param_flat);
    end
    m_reset();
    position = 16'd0; cur_pos = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_accel();
    drive(16'd0, 1);
    drive(16'd1, 0);
    checks++;
    if (edit_value !== 8'd1) begin failures++; $display("[TB] FAIL accel_first: got %0d required 1", edit_value); end
    drive(16'd1, 0);
    drive(16'd1, 0);
    drive(16'd2, 0);
    checks++;
    if (edit_value !== (ACC ? 8'd5 : 8'd2)) begin failures++; $display("[TB] FAIL accel_second: got %0d required %0d", edit_value, ACC ? 5 : 2); end
    for (int i = 0; i < 19; i++) drive(16'd2, 0);
    drive(16'd3, 0);
    checks++;
    if (edit_value !== (ACC ? 8'd6 : 8'd3)) begin failures++; $display("[TB] FAIL accel_third: got %0d required %0d", edit_value, ACC ? 6 : 3); end
    drive(16'd3, 1);
  endtask

  task automatic test_random();
    logic [44:0] act, exp_o;
    int r;
    logic [15:0] np;
    bit b;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 15);
      b = (r == 0) || (r == 1 && $urandom_range(0, 1) == 1);
      if (r >= 1 && r <= 4)      np = cur_pos + 16'($urandom_range(0, 4)) - 16'd2;
      else if (r == 5)           np = 16'($urandom);
      else                       np = cur_pos;
      drive(np, b);
      act = {sel_idx, editing, edit_value, param_flat, commit_pulse, abort_pulse};
      exp_o = m_outputs();
      checks++;
      if (act !== exp_o) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: got %h required %h", c, act, exp_o);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; position = 16'd0; btn_pulse = 1'b0; cur_pos = 16'd0;
    m_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    #1;
    test_nav_wrap();
    test_commit();
    test_saturation();
    test_timeout();
    test_priority();
    test_async_reset();
    test_accel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_param_select.md
# encoder_param_select

Downstream consumer of the quadrature decoder's `position`/`btn_pulse` outputs. It turns detent motion and button presses into a small bank of user-editable parameters using a two-mode UI.
- **NAVIGATE:** rotation selects a parameter.
- **EDIT:** rotation modifies a shadow copy, the button commits it, and inactivity aborts the edit.

The committed bank feeds the rest of the design.

## Interface
Parameters:
- `NUM_PARAMS`, 4: number of parameters; ≥2, power of two.
- `VAL_W`, 8: parameter width, unsigned.
- `VAL_MIN`, 0: lower saturation bound and reset value of every parameter.
- `VAL_MAX`, 255: upper saturation bound; `VAL_MIN` < `VAL_MAX` < 2^`VAL_W`.
- `TIMEOUT_CYCLES`, 50000000: number of idle cycles in EDIT before abort.
- `ACCEL_WINDOW`, 2500000: acceleration window in cycles (used only with `ENC_ACCEL_EN`).
- `ACCEL_GAIN`, 4: step multiplier (used only with `ENC_ACCEL_EN`).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `position`, in, 16: signed detent count from the decoder.
- `btn_pulse`, in, 1: single-cycle debounced press.
- `sel_idx`, out, `$clog2(NUM_PARAMS)`: currently selected parameter.
- `editing`, out, 1: 1 while in EDIT.
- `edit_value`, out, `VAL_W`: shadow value. Equals the selected parameter when not editing.
- `param_flat`, out, `NUM_PARAMS*VAL_W`: committed bank; parameter i occupies `[i*VAL_W +: VAL_W]`.
- `commit_pulse`, out, 1: one cycle, on commit.
- `abort_pulse`, out, 1: one cycle, on timeout abort.

## Operation
- **Delta:** every cycle, `delta = position - pos_prev`, computed as 16-bit two's-complement wrap difference. `pos_prev <= position` every cycle. `pos_prev` resets to 0.
  - Wrap across +32767 → -32768 therefore yields +1.
- **NAVIGATE** (reset state):
  - `btn_pulse` → EDIT. Shadow is loaded with `param[sel_idx]`; timeout counter is cleared.
  - Otherwise, if delta ≠ 0, `sel_idx` moves by ±1 according to sign(delta), regardless of magnitude, and wraps modulo `NUM_PARAMS`.
- **EDIT:**
  - `btn_pulse` → NAVIGATE. `param[sel_idx] <= shadow`; `commit_pulse` fires.
  - Otherwise, if timeout counter = `TIMEOUT_CYCLES-1` → NAVIGATE. Shadow is discarded, the parameter is unchanged, and `abort_pulse` fires.
  - Otherwise, if delta ≠ 0: `shadow <= sat(shadow + step)` and the timeout counter clears.
  - Otherwise the timeout counter increments.
- **Arithmetic:**
  - `step` = delta sign-extended; with `ENC_ACCEL_EN` it may be multiplied by `ACCEL_GAIN`.
  - The sum is evaluated in at least `VAL_W+20` signed bits, then saturated to [`VAL_MIN`, `VAL_MAX`].
  - No wrap-around on values, ever.
- **Priority:** `btn_pulse` outranks timeout, which outranks delta. A delta arriving in the same cycle as `btn_pulse` or timeout is discarded; `pos_prev` still updates.
- **Reset** (any time, including mid-edit):
  - `sel_idx`=0, `editing`=0.
  - All params = `VAL_MIN`; shadow = `VAL_MIN`.
  - Pulses = 0; counters = 0; `pos_prev`=0.
- `edit_value` is the shadow in EDIT; in NAVIGATE it mirrors `param[sel_idx]` combinationally from registers.

## Timing
- Every state and output is registered. An event sampled at edge N is visible after edge N+1.
- `btn_pulse` at cycle N produces the following at N+1, with no further latency:
  - `editing` toggles.
  - On commit, `commit_pulse`=1 and `param_flat` holds the new value, in the same cycle.
- `commit_pulse` and `abort_pulse` are high for exactly one cycle. They are mutually exclusive.
- Timeout: abort occurs `TIMEOUT_CYCLES` cycles after the last accepted delta or EDIT entry.
- Back-to-back `btn_pulse` on consecutive cycles is legal and is processed each cycle.

## Configuration
- **`ENC_ACCEL_EN` defined:**
  - A window counter tracks cycles since the last nonzero delta in EDIT; it saturates at `ACCEL_WINDOW`.
  - A nonzero delta arriving while the counter < `ACCEL_WINDOW` uses `step = delta*ACCEL_GAIN`. Otherwise `step = delta`.
  - The counter resets to `ACCEL_WINDOW` (i.e., not accelerated) on EDIT entry and on reset.
- **Undefined:** `step = delta` always; the window logic is absent.

## Test plan
All scenarios use `NUM_PARAMS`=4, `VAL_W`=8, `VAL_MIN`=0, `VAL_MAX`=255, `TIMEOUT_CYCLES`=100, `ACCEL_WINDOW`=10, unless noted.

- **Navigation wrap:** release `rst_n`; `position` 0→-1 → `sel_idx`=3 next cycle; then -1→+3 in a single step → `sel_idx`=0 (one move only).
- **Commit:**
  1. `btn_pulse` → `editing`=1.
  2. Five +1 detents → `edit_value`=5.
  3. `btn_pulse` → `commit_pulse` for 1 cycle, `param_flat[7:0]`=5, `editing`=0.
- **Saturation:**
  - In EDIT on param 1, `position` jumps +300 → `edit_value`=255.
  - Then -1000 → 0.
  - `position` wrap 32767→-32768 → +1 step.
- **Timeout abort:** enter EDIT, one +1 detent, then idle 100 cycles → `abort_pulse` exactly once, `editing`=0, param unchanged (0).
- **Priority / async reset:**
  - `btn_pulse` and a +1 delta in the same cycle in NAVIGATE → EDIT entered, `sel_idx` unchanged.
  - Assert `rst_n` low mid-edit, between edges → all outputs at reset values immediately.
- **`ENC_ACCEL_EN` build:**
  - Two +1 detents 3 cycles apart in EDIT → value 1 then 5.
  - A third detent 20 cycles later → 6.
  - Undefined build gives 1, 2, 3.
